eth_rx_fcs_check: RTL and testbench
===================================

// Module: eth_rx_fcs_check
// PURPOSE
// Receive-side counterpart of the transmit FCS path. Takes the byte stream from
// the gig_eth_pcs_pma receive side, strips the preamble and SFD, and runs CRC-32
// over every byte after the SFD. It strips the 4-byte FCS, forwards the payload
// as a valid/last byte stream, and reports per-frame status. It sits between the
// PCS/PMA and the XVC packet parser.
// PARAMETERS
// MIN_FRAME    64             min bytes after SFD incl. FCS; shorter -> len_err
// MAX_FRAME    1522           max bytes after SFD incl. FCS; longer -> len_err
// CRC_RESIDUE  32'hC704DD7B   CRC register value after a good frame incl. FCS
// PORTS
// clock        in   1   single system clock, all logic on posedge
// reset        in   1   asynchronous, active-low; 0 clears all state
// rx_data      in   8   received byte, d[0] = first serial bit
// rx_dv        in   1   byte valid; high for the whole frame incl. preamble
// rx_er        in   1   PCS error strobe for the current byte
// m_data       out  8   payload byte (FCS removed)
// m_valid      out  1   m_data valid this cycle
// m_last       out  1   m_data is the final payload byte of the frame
// frame_done   out  1   1-cycle pulse: frame ended, status outputs valid
// frame_ok     out  1   CRC match && no len_err && no rx_er (valid on frame_done)
// crc_err      out  1   CRC residue mismatch (valid on frame_done)
// len_err      out  1   length outside [MIN_FRAME, MAX_FRAME] (valid on frame_done)
// phy_err      out  1   rx_er seen during the frame (valid on frame_done)
// BEHAVIOUR
// - Reset (reset==0): FSM=IDLE, crc=FFFFFFFF, count=0, buffer empty.
//   Every output is 0. Reset during a frame abandons it with no frame_done.
// - FSM states, in a cycle where rx_dv==1:
//   IDLE->PRE on any byte; byte==D5 in IDLE -> DROP (at least one 55 is required).
//   PRE: 55 stays in PRE; D5 -> DATA (crc<=FFFFFFFF, count<=0, flags cleared);
//        any other byte -> DROP.
//   DATA: each byte updates crc with the 8-bit parallel CRC-32 equations, poly
//         04C11DB7, d[0] first; count increments, saturating at MAX_FRAME+1.
//         The byte is pushed into the 5-byte delay buffer. rx_er sets phy_err_r.
//   DROP: ignore bytes until rx_dv==0.
// - Any state with rx_dv==0 -> IDLE. PRE or DROP exit silently, with no frame_done.
// - Payload emit: once the buffer holds 5 bytes, each DATA byte pushes one out.
//   DATA byte k+5 sampled at cycle t -> m_data=byte k, m_valid=1 at t+1 (1-cycle latency).
// - End of frame, first cycle with rx_dv==0 in DATA (L = count):
//   next cycle: m_data=byte L-5, m_valid=1, m_last=1, and frame_done=1 in the same cycle.
//   crc_err = (crc != CRC_RESIDUE).
//   len_err = (L<MIN_FRAME || L>MAX_FRAME).
//   phy_err = phy_err_r.
//   frame_ok = ~(crc_err|len_err|phy_err).
// - L<5: no payload byte is emitted (m_valid never 1); frame_done=1, frame_ok=0.
// - Oversize frames still stream payload; only len_err flags them. Downstream
//   discards on frame_ok==0.
// - m_valid, m_last, frame_done and the status outputs are 0 except in the cycles
//   defined above. Status is held only for the frame_done cycle.
// - Back-to-back frames: rx_dv may rise on the cycle right after the end cycle.
//   IDLE accepts it, so no inter-frame gap is required.
// - No backpressure: downstream must accept every m_valid byte.
// TESTING
// - Reset low mid-DATA, then high: all outputs 0, no frame_done; next good frame
//   is received normally.
// - 7x55, D5, 60 bytes 00..3B, correct FCS (bench reference CRC):
//   60 m_valid bytes 00..3B, m_last on 3B, frame_done=1, frame_ok=1.
// - Same frame with bit 0 of payload byte 10 flipped: payload streams,
//   crc_err=1, frame_ok=0.
// - 55,55,A5,...: DROP, no m_valid, no frame_done; then 55,D5 frame received ok.
// - 20-byte frame with valid FCS: 16 bytes out, len_err=1, crc_err=0, frame_ok=0.
//   1530-byte frame: len_err=1.
// - rx_er=1 on byte 30 of a good frame: phy_err=1, frame_ok=0.
//   Second frame with rx_dv re-asserted 1 cycle after the end: both frames pass.

Source files
------------

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: strips preamble/SFD, checks CRC-32 and length,
// forwards the payload with the 4-byte FCS removed and reports per-frame status.
module eth_rx_fcs_check #(
    parameter int          MIN_FRAME   = 64,
    parameter int          MAX_FRAME   = 1522,
    parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_dv,
    input  logic       rx_er,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       crc_err,
    output logic       len_err,
    output logic       phy_err
);

    localparam int CW = $clog2(MAX_FRAME + 2);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t         state;
    state_t         state_nx;
    logic [31:0]    crc;
    logic [CW-1:0]  count;
    logic [4:0][7:0] sr;
    logic [2:0]     fill;
    logic           phy_err_r;

    logic       sfd_hit;
    logic       data_byte;
    logic       frame_end;
    logic       buf_full;
    logic [7:0] m_data_nx;
    logic       m_valid_nx;
    logic       m_last_nx;
    logic       done_nx;
    logic       crc_err_nx;
    logic       len_err_nx;
    logic       phy_err_nx;
    logic       ok_nx;

    // Serial CRC-32 unrolled over one byte, d[0] enters first.
    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i])
                r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    assign sfd_hit   = (state == PRE) && rx_dv && (rx_data == 8'hD5);
    assign data_byte = (state == DATA) && rx_dv;
    assign frame_end = (state == DATA) && !rx_dv;
    assign buf_full  = (fill == 3'd5);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!rx_dv) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nx = (rx_data == 8'hD5) ? DROP : PRE;
                PRE: begin
                    if (rx_data == 8'hD5)
                        state_nx = DATA;
                    else if (rx_data != 8'h55)
                        state_nx = DROP;
                end
                DATA: state_nx = DATA;
                DROP: state_nx = DROP;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        m_valid_nx = buf_full && (data_byte || frame_end);
        m_last_nx  = buf_full && frame_end;
        m_data_nx  = m_valid_nx ? sr[4] : 8'h00;
        done_nx    = frame_end;
        crc_err_nx = frame_end && (crc != CRC_RESIDUE);
        len_err_nx = frame_end && ((count < CW'(MIN_FRAME)) ||
                                   (count > CW'(MAX_FRAME)));
        phy_err_nx = frame_end && phy_err_r;
        ok_nx      = frame_end && !(crc_err_nx || len_err_nx || phy_err_nx);
    end

    // sr[0] holds the newest byte, sr[4] the oldest still-unsent byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc       <= 32'hFFFF_FFFF;
            count     <= '0;
            sr        <= '0;
            fill      <= '0;
            phy_err_r <= 1'b0;
        end else if (sfd_hit) begin
            crc       <= 32'hFFFF_FFFF;
            count     <= '0;
            fill      <= '0;
            phy_err_r <= 1'b0;
        end else if (data_byte) begin
            crc <= crc_step(crc, rx_data);
            if (count != CW'(MAX_FRAME + 1))
                count <= count + 1'b1;
            sr <= {sr[3:0], rx_data};
            if (!buf_full)
                fill <= fill + 3'd1;
            if (rx_er)
                phy_err_r <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            phy_err    <= 1'b0;
        end else begin
            m_data     <= m_data_nx;
            m_valid    <= m_valid_nx;
            m_last     <= m_last_nx;
            frame_done <= done_nx;
            frame_ok   <= ok_nx;
            crc_err    <= crc_err_nx;
            len_err    <= len_err_nx;
            phy_err    <= phy_err_nx;
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check: reference FCS, payload and
// status expectations queued at drive time, compared as the DUT emits.
module tb_eth_rx_fcs_check;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic       rx_er;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       frame_done;
    logic       frame_ok;
    logic       crc_err;
    logic       len_err;
    logic       phy_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] exp_q[$];
    logic [3:0] stat_q[$];
    logic [7:0] pl[$];

    eth_rx_fcs_check dut (
        .clock      (clk),
        .reset      (rst_n),
        .rx_data    (rx_data),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .crc_err    (crc_err),
        .len_err    (len_err),
        .phy_err    (phy_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Standard reflected Ethernet CRC-32.
    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic drive(input logic [7:0] d, input logic dv,
                         input logic er);
        @(posedge clk);
        #1;
        rx_data = d;
        rx_dv   = dv;
        rx_er   = er;
    endtask

    task automatic fill_pl(input int n, input int start);
        pl.delete();
        for (int i = 0; i < n; i++)
            pl.push_back(8'((start + i) & 8'hFF));
    endtask

    // Sends pl with FCS; flip_idx corrupts bit 0 of a payload byte after FCS
    // is computed, er_idx raises rx_er on that post-SFD byte.
    task automatic send(input int npre, input int flip_idx,
                        input int er_idx, input int gap);
        logic [31:0] fcs;
        logic [7:0]  fr[$];
        int          len;
        logic        ce, le, pe;
        fcs = ref_crc(pl);
        fr = pl;
        if (flip_idx >= 0)
            fr[flip_idx] = fr[flip_idx] ^ 8'h01;
        for (int i = 0; i < 4; i++)
            fr.push_back(fcs[8*i +: 8]);
        len = fr.size();
        if (len >= 5)
            for (int i = 0; i < pl.size(); i++)
                exp_q.push_back({i == pl.size() - 1, fr[i]});
        ce = (flip_idx >= 0);
        le = (len < 64) || (len > 1522);
        pe = (er_idx >= 0);
        stat_q.push_back({ce, le, pe, !(ce || le || pe)});
        for (int i = 0; i < npre; i++)
            drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        foreach (fr[i])
            drive(fr[i], 1'b1, i == er_idx);
        for (int g = 0; g < gap; g++)
            drive(8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexp_valid", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(e[7:0]));
                    check("m_last", 32'(m_last), 32'(e[8]));
                end
            end else if (m_last) begin
                check("stray_last", 32'(m_last), 32'h0);
            end
            if (frame_done) begin
                if (stat_q.size() == 0) begin
                    check("unexp_done", 32'(frame_done), 32'h0);
                end else begin
                    logic [3:0] s;
                    s = stat_q.pop_front();
                    check("status", 32'({crc_err, len_err, phy_err, frame_ok}),
                          32'(s));
                end
            end else if ({crc_err, len_err, phy_err, frame_ok} != 4'b0) begin
                check("stray_status",
                      32'({crc_err, len_err, phy_err, frame_ok}), 32'h0);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({m_data, m_valid, m_last, frame_done,
                                 frame_ok, crc_err, len_err, phy_err}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Abandon a frame mid-DATA with reset.
        for (int i = 0; i < 7; i++)
            drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(8'(i), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_dv = 1'b0;
        @(negedge clk);
        check("midreset_outs", 32'({m_data, m_valid, m_last, frame_done,
                                    frame_ok, crc_err, len_err, phy_err}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(8'h00, 1'b0, 1'b0);

        fill_pl(60, 0);
        send(7, -1, -1, 3);

        fill_pl(60, 0);
        send(7, 10, -1, 3);

        // Bad SFD: 55,55,A5 must drop silently.
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            drive(8'(8'h30 + i), 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        fill_pl(60, 8'h40);
        send(1, -1, -1, 2);

        fill_pl(16, 8'h80);
        send(7, -1, -1, 3);

        fill_pl(1526, 8'h11);
        send(7, -1, -1, 3);

        fill_pl(60, 8'h20);
        send(7, -1, 30, 1);
        fill_pl(70, 8'h90);
        send(7, -1, -1, 3);

        fill_pl(0, 0);
        send(7, -1, -1, 3);

        for (int i = 0; i < 200 && (exp_q.size() != 0 || stat_q.size() != 0); i++)
            @(posedge clk);
        check("drain_payload", 32'(exp_q.size()), 32'h0);
        check("drain_status", 32'(stat_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
